// File: rtl/alu16_pkg.sv
// Shared constants for the Hack-style ALU stage: ctrl bit positions, named
// ctrl encodings and the FIFO entry layout {res, zr, ng}.
package alu16_pkg;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned ENTRY_W  = DATA_W + 2;

   localparam int unsigned CTRL_ZX  = 5;
   localparam int unsigned CTRL_NX  = 4;
   localparam int unsigned CTRL_ZY  = 3;
   localparam int unsigned CTRL_NY  = 2;
   localparam int unsigned CTRL_F   = 1;
   localparam int unsigned CTRL_NO  = 0;

   localparam logic [5:0] ALU_ZERO  = 6'b101010;
   localparam logic [5:0] ALU_ONE   = 6'b111111;
   localparam logic [5:0] ALU_X     = 6'b001100;
   localparam logic [5:0] ALU_NOTX  = 6'b001101;
   localparam logic [5:0] ALU_XPY   = 6'b000010;
   localparam logic [5:0] ALU_XMY   = 6'b010011;
   localparam logic [5:0] ALU_XANDY = 6'b000000;

   function automatic logic [ENTRY_W-1:0] pack_entry(input logic [DATA_W-1:0] res,
                                                     input logic zr, input logic ng);
      return {res, zr, ng};
   endfunction
endpackage

// File: rtl/alu16_pipe_if.sv
// Operand-in / result-out handshake bundle for alu16_pipe.
interface alu16_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x;
   logic [15:0] y;
   logic [5:0]  ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out;
   logic        zr;
   logic        ng;
   logic [15:0] op_count;

   modport master (
      output in_valid, x, y, ctrl, out_ready,
      input  in_ready, out_valid, out, zr, ng, op_count
   );
   modport slave (
      input  in_valid, x, y, ctrl, out_ready,
      output in_ready, out_valid, out, zr, ng, op_count
   );
endinterface

// File: rtl/alu16_core.sv
// Combinational Hack ALU: zero/negate each operand, add or AND, optionally
// negate the result, and flag zero/negative.
module alu16_core
   import alu16_pkg::*;
(
   input  logic [15:0] i_x,
   input  logic [15:0] i_y,
   input  logic [5:0]  i_ctrl,
   output logic [15:0] o_res,
   output logic        o_zr,
   output logic        o_ng
);
   logic [15:0] w_x1, w_y1, w_nx1, w_ny1, w_x2, w_y2, w_r, w_nr;

   assign w_x1 = i_ctrl[CTRL_ZX] ? 16'h0000 : i_x;
   assign w_y1 = i_ctrl[CTRL_ZY] ? 16'h0000 : i_y;

   Not16 u_not_x (.i_a(w_x1), .o_y(w_nx1));
   Not16 u_not_y (.i_a(w_y1), .o_y(w_ny1));

   assign w_x2 = i_ctrl[CTRL_NX] ? w_nx1 : w_x1;
   assign w_y2 = i_ctrl[CTRL_NY] ? w_ny1 : w_y1;

   // Carry-out of the add is intentionally dropped.
   assign w_r  = i_ctrl[CTRL_F] ? (w_x2 + w_y2) : (w_x2 & w_y2);

   Not16 u_not_r (.i_a(w_r), .o_y(w_nr));

   assign o_res = i_ctrl[CTRL_NO] ? w_nr : w_r;
   assign o_zr  = (o_res == 16'h0000);
   assign o_ng  = o_res[15];
endmodule

// File: rtl/not16.sv
// 16-bit bitwise inverter, the Hack Not16 building block.
module Not16 (
   input  logic [15:0] i_a,
   output logic [15:0] o_y
);
   assign o_y = ~i_a;
endmodule

// File: rtl/alu16_pipe.sv
// Registered ALU stage: results (with flags) are buffered in a 2-entry FIFO so
// in_ready depends only on the registered fill count, never on out_ready.
module alu16_pipe
   import alu16_pkg::*;
(
   input logic         clk,
   input logic         rst_n,
   alu16_pipe_if.slave bus
);
   logic [DATA_W-1:0]  w_res;
   logic               w_zr, w_ng;
   logic               w_push, w_pop;
   logic [ENTRY_W-1:0] w_head;

   logic [ENTRY_W-1:0] r_fifo [2];
   logic               r_wr_ptr, r_rd_ptr;
   logic [1:0]         r_count;
   logic [15:0]        r_op_count;

   alu16_core u_core (
      .i_x    (bus.x),
      .i_y    (bus.y),
      .i_ctrl (bus.ctrl),
      .o_res  (w_res),
      .o_zr   (w_zr),
      .o_ng   (w_ng)
   );

   assign bus.in_ready  = (r_count != 2'd2);
   assign bus.out_valid = (r_count != 2'd0);
   assign w_push        = bus.in_valid && bus.in_ready;
   assign w_pop         = bus.out_valid && bus.out_ready;

   // Empty FIFO presents zeros rather than stale storage.
   assign w_head       = bus.out_valid ? r_fifo[r_rd_ptr] : '0;
   assign bus.out      = w_head[ENTRY_W-1:2];
   assign bus.zr       = w_head[1];
   assign bus.ng       = w_head[0];
   assign bus.op_count = r_op_count;

   always_ff @(posedge clk) begin
      if (rst_n && w_push)
         r_fifo[r_wr_ptr] <= pack_entry(w_res, w_zr, w_ng);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_op_count <= 16'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop) begin
            r_rd_ptr   <= ~r_rd_ptr;
            r_op_count <= r_op_count + 16'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_alu16_pipe.sv
// Self-checking bench for alu16_pipe: directed spec vectors, backpressure,
// reset, op_count wrap and randomized traffic against a queue-based model.
module tb_alu16_pipe;
   import alu16_pkg::*;

   logic clk;
   logic rst_n;
   alu16_pipe_if bus();

   alu16_pipe u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [17:0] q[$];
   logic [15:0] m_opcnt;

   function automatic logic [17:0] alu_ref(input logic [15:0] xv, input logic [15:0] yv,
                                           input logic [5:0] c);
      logic [15:0] a, b, r;
      a = c[5] ? 16'd0 : xv;
      if (c[4]) a = 16'hFFFF - a;
      b = c[3] ? 16'd0 : yv;
      if (c[2]) b = 16'hFFFF - b;
      r = c[1] ? 16'((32'(a) + 32'(b)) % 32'h10000) : (a & b);
      if (c[0]) r = 16'hFFFF - r;
      return {r, (r == 16'd0), r[15]};
   endfunction

   // Drive one cycle from a negedge; model updated at the posedge from its own count.
   task automatic drive_cycle(input logic iv, input logic [15:0] xv, input logic [15:0] yv,
                              input logic [5:0] cv, input logic ordy);
      logic do_push, do_pop;
      bus.in_valid  = iv;
      bus.x         = xv;
      bus.y         = yv;
      bus.ctrl      = cv;
      bus.out_ready = ordy;
      do_push = iv && (q.size() < 2);
      do_pop  = ordy && (q.size() > 0);
      @(posedge clk);
      if (do_pop) begin
         q.delete(0);
         m_opcnt = m_opcnt + 16'd1;
      end
      if (do_push) q.push_back(alu_ref(xv, yv, cv));
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      m_opcnt = 16'd0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.out, bus.zr, bus.ng, bus.op_count} !==
          {1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0}) begin
         n_err++;
         $display("FAIL reset_state: got vld=%b rdy=%b out=%h zr=%b ng=%b cnt=%h, want 0 1 0000 0 0 0000",
                  bus.out_valid, bus.in_ready, bus.out, bus.zr, bus.ng, bus.op_count);
      end
   endtask

   task automatic test_basic_ops();
      logic [15:0] xs [7];
      logic [15:0] ys [7];
      logic [5:0]  cs [7];
      logic [17:0] ex [7];
      xs = '{16'd5, 16'($urandom), 16'($urandom), 16'd3, 16'hFFFF, 16'h0F0F, 16'h0F0F};
      ys = '{16'd3, 16'($urandom), 16'($urandom), 16'd5, 16'h0001, 16'h00FF, 16'($urandom)};
      cs = '{ALU_XPY, ALU_ZERO, ALU_ONE, ALU_XMY, ALU_XPY, ALU_XANDY, ALU_NOTX};
      ex = '{{16'h0008, 2'b00}, {16'h0000, 2'b10}, {16'h0001, 2'b00}, {16'hFFFE, 2'b01},
             {16'h0000, 2'b10}, {16'h000F, 2'b00}, {16'hF0F0, 2'b01}};
      for (int i = 0; i < 7; i++) begin
         drive_cycle(1'b1, xs[i], ys[i], cs[i], 1'b1);
         n_cmp++;
         if ({bus.out_valid, bus.out, bus.zr, bus.ng} !== {1'b1, ex[i]}) begin
            n_err++;
            $display("FAIL basic_op%0d: got vld=%b out=%h zr=%b ng=%b, want 1 %h %b %b",
                     i, bus.out_valid, bus.out, bus.zr, bus.ng, ex[i][17:2], ex[i][1], ex[i][0]);
         end
      end
      drive_cycle(1'b0, 16'd0, 16'd0, 6'd0, 1'b1);
      n_cmp++;
      if ({bus.out_valid, bus.op_count} !== {1'b0, m_opcnt}) begin
         n_err++;
         $display("FAIL basic_drain: got vld=%b cnt=%h, want 0 %h", bus.out_valid, bus.op_count, m_opcnt);
      end
   endtask

   task automatic test_backpressure();
      logic [17:0] ea, eb, ec;
      apply_reset();
      ea = alu_ref(16'd10, 16'd20, ALU_XPY);
      eb = alu_ref(16'd7,  16'd9,  ALU_XMY);
      ec = alu_ref(16'h1234, 16'h0, ALU_NOTX);
      drive_cycle(1'b1, 16'd10, 16'd20, ALU_XPY, 1'b0);
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.out} !== {1'b1, 1'b1, ea[17:2]}) begin
         n_err++;
         $display("FAIL bp_after_A: got rdy=%b vld=%b out=%h, want 1 1 %h", bus.in_ready, bus.out_valid, bus.out, ea[17:2]);
      end
      drive_cycle(1'b1, 16'd7, 16'd9, ALU_XMY, 1'b0);
      n_cmp++;
      if ({bus.in_ready, bus.out} !== {1'b0, ea[17:2]}) begin
         n_err++;
         $display("FAIL bp_after_B: got rdy=%b out=%h, want 0 %h", bus.in_ready, bus.out, ea[17:2]);
      end
      drive_cycle(1'b1, 16'h1234, 16'h0, ALU_NOTX, 1'b0);
      n_cmp++;
      if ({bus.in_ready, bus.out} !== {1'b0, ea[17:2]}) begin
         n_err++;
         $display("FAIL bp_C_held: got rdy=%b out=%h, want 0 %h", bus.in_ready, bus.out, ea[17:2]);
      end
      drive_cycle(1'b1, 16'h1234, 16'h0, ALU_NOTX, 1'b1);
      n_cmp++;
      if ({bus.in_ready, bus.out, bus.op_count} !== {1'b1, eb[17:2], 16'd1}) begin
         n_err++;
         $display("FAIL bp_pop_A: got rdy=%b out=%h cnt=%h, want 1 %h 0001", bus.in_ready, bus.out, bus.op_count, eb[17:2]);
      end
      drive_cycle(1'b1, 16'h1234, 16'h0, ALU_NOTX, 1'b1);
      n_cmp++;
      if ({bus.out_valid, bus.out, bus.zr, bus.ng, bus.op_count} !== {1'b1, ec, 16'd2}) begin
         n_err++;
         $display("FAIL bp_head_C: got vld=%b out=%h zr=%b ng=%b cnt=%h, want 1 %h %b %b 0002",
                  bus.out_valid, bus.out, bus.zr, bus.ng, bus.op_count, ec[17:2], ec[1], ec[0]);
      end
      drive_cycle(1'b0, 16'd0, 16'd0, 6'd0, 1'b1);
      n_cmp++;
      if ({bus.out_valid, bus.op_count} !== {1'b0, 16'd3}) begin
         n_err++;
         $display("FAIL bp_final: got vld=%b cnt=%h, want 0 0003", bus.out_valid, bus.op_count);
      end
   endtask

   task automatic test_reset_mid();
      drive_cycle(1'b1, 16'd1, 16'd2, ALU_XPY, 1'b0);
      drive_cycle(1'b1, 16'd3, 16'd4, ALU_XPY, 1'b0);
      n_cmp++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL rstmid_full: got vld=%b rdy=%b, want 1 0", bus.out_valid, bus.in_ready);
      end
      apply_reset();
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.out, bus.zr, bus.ng, bus.op_count} !==
          {1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0}) begin
         n_err++;
         $display("FAIL rstmid_clear: got vld=%b rdy=%b out=%h zr=%b ng=%b cnt=%h, want 0 1 0000 0 0 0000",
                  bus.out_valid, bus.in_ready, bus.out, bus.zr, bus.ng, bus.op_count);
      end
   endtask

   task automatic test_random();
      logic [5:0]  named [7];
      logic [17:0] eh;
      logic [5:0]  c;
      named = '{ALU_ZERO, ALU_ONE, ALU_X, ALU_NOTX, ALU_XPY, ALU_XMY, ALU_XANDY};
      for (int i = 0; i < 400; i++) begin
         c = ($urandom_range(1, 0) == 1) ? named[$urandom_range(6, 0)] : 6'($urandom);
         drive_cycle(1'($urandom_range(3, 0) != 0), 16'($urandom), 16'($urandom), c,
                     1'($urandom_range(2, 0) != 0));
         eh = (q.size() != 0) ? q[0] : 18'd0;
         n_cmp++;
         if ({bus.out_valid, bus.in_ready, bus.out, bus.zr, bus.ng, bus.op_count} !==
             {(q.size() != 0), (q.size() != 2), eh, m_opcnt}) begin
            n_err++;
            $display("FAIL random_%0d: got vld=%b rdy=%b out=%h zr=%b ng=%b cnt=%h, want %b %b %h %b %b %h",
                     i, bus.out_valid, bus.in_ready, bus.out, bus.zr, bus.ng, bus.op_count,
                     (q.size() != 0), (q.size() != 2), eh[17:2], eh[1], eh[0], m_opcnt);
         end
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i <= 65536; i++) begin
         drive_cycle(1'b1, 16'($urandom), 16'($urandom), 6'($urandom), 1'b1);
         if (i == 65535) begin
            n_cmp++;
            if (bus.op_count !== 16'hFFFF) begin
               n_err++;
               $display("FAIL wrap_ffff: got cnt=%h, want ffff", bus.op_count);
            end
         end
      end
      n_cmp++;
      if ({bus.op_count, bus.out_valid, bus.out} !== {16'h0000, 1'b1, q[0][17:2]}) begin
         n_err++;
         $display("FAIL wrap_zero: got cnt=%h vld=%b out=%h, want 0000 1 %h",
                  bus.op_count, bus.out_valid, bus.out, q[0][17:2]);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.x         = 16'd0;
      bus.y         = 16'd0;
      bus.ctrl      = 6'd0;
      m_opcnt       = 16'd0;
      @(negedge clk);
      test_reset();
      test_basic_ops();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
